// File: rtl/wb_reg_initiator_if.sv
// -----------------------------------------------------------------------------
// wb_reg_initiator_if
// Bundles the two buses handled by the Wishbone-to-register-bus bridge.
//   Wishbone side : wbs_cyc_i, wbs_stb_i, wbs_adr_i[10:0], wbs_we_i,
//                   wbs_dat_i[31:0], wbs_sel_i[3:0] -> bridge;
//                   wbs_dat_o[31:0], wbs_ack_o, wbs_err_o <- bridge
//   Register side : reg_cs, reg_wr, reg_addr[10:0], reg_wdata[31:0],
//                   reg_be[3:0] <- bridge;
//                   reg_rdata[31:0], reg_ack, reg_err, reg_sid[3:0] -> bridge
// Modports:
//   slave  - the bridge (Wishbone slave, register-bus initiator)
//   master - the environment (Wishbone master plus register responder)
// -----------------------------------------------------------------------------
interface wb_reg_initiator_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [10:0] wbs_adr_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  logic        reg_cs;
  logic        reg_wr;
  logic [10:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        reg_err;
  logic [3:0]  reg_sid;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack, reg_err, reg_sid
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack, reg_err, reg_sid
  );
endinterface

// File: rtl/wb_reg_initiator.sv
// -----------------------------------------------------------------------------
// wb_reg_initiator
// Wishbone slave to register-bus initiator bridge with an ack timeout.
// A Wishbone request is registered onto the register bus; the responder's
// reg_ack (or a timeout after TMO_CYC cycles) completes it with a one-cycle
// wbs_ack_o / wbs_err_o pulse. A dropped wbs_cyc_i suppresses the pulse but
// the register transfer and status capture still complete.
// Ports:
//   app_clk, reset_ssn  clock, asynchronous active-low reset
//   bus                 Wishbone + register bus (slave modport)
//   sts_clr             clears the sticky timeout flag
//   sts_tmo             sticky timeout flag
//   sts_last_sid        reg_sid captured at the last completed transfer
// -----------------------------------------------------------------------------
module wb_reg_initiator #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                 app_clk,
  input  logic                 reset_ssn,
  wb_reg_initiator_if.slave    bus,
  input  logic                 sts_clr,
  output logic                 sts_tmo,
  output logic [3:0]           sts_last_sid
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_e             state_q, state_d;
  logic               cs_q, cs_d;
  logic               wr_q, wr_d;
  logic [10:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        dat_q, dat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic [3:0]         sid_q, sid_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;

  logic               start;
  logic               abort_now;

  assign start = bus.wbs_cyc_i & bus.wbs_stb_i;
  // The master may drop cyc in any REQ cycle, including the completing one.
  assign abort_now = abort_q | ~bus.wbs_cyc_i;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = sts_clr ? 1'b0 : tmo_q;
    sid_d   = sid_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;

    unique case (state_q)
      // DONE is the single cs-low cycle after a completion. The pulse cycle
      // has already shown ack/err to the master, which presents its next
      // request during it, so DONE accepts a request exactly like IDLE.
      IDLE, DONE: begin
        cs_d    = 1'b0;
        state_d = IDLE;
        if (start) begin
          addr_d  = bus.wbs_adr_i;
          wr_d    = bus.wbs_we_i;
          wdata_d = bus.wbs_dat_i;
          be_d    = bus.wbs_sel_i;
          cs_d    = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        cnt_d   = cnt_q + 1'b1;
        abort_d = abort_now;
        if (bus.reg_ack) begin
          // Ack wins over a timeout landing in the same cycle.
          cs_d  = 1'b0;
          sid_d = bus.reg_sid;
          if (!wr_q) dat_d = bus.reg_rdata;
          ack_d   = ~abort_now & ~bus.reg_err;
          err_d   = ~abort_now & bus.reg_err;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          cs_d    = 1'b0;
          err_d   = ~abort_now;
          tmo_d   = 1'b1;
          dat_d   = {16'hDEAD, 5'd0, addr_q};
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: the datapath registers are reset as well, since their reset values
  // (wbs_dat_o, sts_last_sid) are visible to software.
  always_ff @(posedge app_clk or negedge reset_ssn) begin
    if (!reset_ssn) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      sid_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      sid_q   <= sid_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign bus.reg_cs    = cs_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = be_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = err_q;
  assign sts_tmo       = tmo_q;
  assign sts_last_sid  = sid_q;

endmodule

// File: tb/tb_wb_reg_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_reg_initiator
// Directed and randomized transfers against wb_reg_initiator. The expected
// response of each transfer is derived from the responder delay: a reply in
// cs-high cycle k (0 <= k < TMO_CYC) completes after k+1 cs-high cycles,
// otherwise the transfer times out after TMO_CYC cycles.
// -----------------------------------------------------------------------------
module tb_wb_reg_initiator;

  localparam int TMO_CYC = 255;

  logic       app_clk = 1'b0;
  logic       reset_ssn;
  logic       sts_clr;
  logic       sts_tmo;
  logic [3:0] sts_last_sid;

  wb_reg_initiator_if bus ();

  wb_reg_initiator #(.TMO_W(8), .TMO_CYC(TMO_CYC)) dut (
    .app_clk      (app_clk),
    .reset_ssn    (reset_ssn),
    .bus          (bus.slave),
    .sts_clr      (sts_clr),
    .sts_tmo      (sts_tmo),
    .sts_last_sid (sts_last_sid)
  );

  always #5 app_clk = ~app_clk;

  int checks = 0;
  int errors = 0;

  // Reference status model.
  logic [31:0] exp_dat;
  logic        exp_tmo;
  logic [3:0]  exp_sid;
  int          lo_run;
  int          last_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk();
    bus.reg_ack   = 1'($urandom_range(0, 1));
    bus.reg_err   = 1'($urandom_range(0, 1));
    bus.reg_sid   = 4'($urandom);
    bus.reg_rdata = $urandom;
  endtask

  // One transfer. k < 0 means the responder never acks. Returns at the
  // falling edge of the cycle in which the response pulse is expected.
  task automatic xfer(input string tag, input logic [10:0] adr, input logic we,
                      input logic [31:0] dat, input logic [3:0] sel, input int k,
                      input logic rerr, input logic [3:0] sid, input logic [31:0] rdata,
                      input bit abort, input bit keep, input bit clr_race);
    bit timeout, seen_hi, done, stable_ok;
    int n, cs_high, acks, errs, both, exp_cs;
    logic exp_ack, exp_err, end_ack, end_err;
    timeout = !(k >= 0 && k <= TMO_CYC - 1);
    exp_cs  = timeout ? TMO_CYC : k + 1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    n = -1; seen_hi = 0; done = 0; stable_ok = 1;
    cs_high = 0; acks = 0; errs = 0; both = 0;
    end_ack = 1'b0; end_err = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge app_clk);
      if (bus.wbs_ack_o === 1'b1) acks++;
      if (bus.wbs_err_o === 1'b1) errs++;
      if (bus.wbs_ack_o === 1'b1 && bus.wbs_err_o === 1'b1) both++;
      if (bus.reg_cs === 1'b1) begin
        if (!seen_hi) begin
          seen_hi  = 1;
          last_gap = lo_run;
        end
        lo_run = 0;
        n++;
        cs_high++;
        if (bus.reg_addr !== adr || bus.reg_wr !== we ||
            bus.reg_wdata !== dat || bus.reg_be !== sel) stable_ok = 0;
        bus.reg_ack   = (n == k);
        bus.reg_err   = (n == k) ? rerr : 1'($urandom_range(0, 1));
        bus.reg_sid   = (n == k) ? sid : 4'($urandom);
        bus.reg_rdata = (n == k) ? rdata : $urandom;
        sts_clr       = clr_race && (n == TMO_CYC - 1);
        if (abort && n == 1) begin
          bus.wbs_cyc_i = 1'b0;
          bus.wbs_stb_i = 1'b0;
        end
      end else begin
        lo_run++;
        if (seen_hi) begin
          done    = 1;
          end_ack = bus.wbs_ack_o;
          end_err = bus.wbs_err_o;
        end
        drive_junk();
        sts_clr = 1'b0;
      end
    end

    // Model update.
    if (!timeout) begin
      if (!we) exp_dat = rdata;
      exp_sid = sid;
    end else begin
      exp_tmo = 1'b1;
      exp_dat = 32'hDEAD_0000 | {21'd0, adr};
    end
    exp_ack = !abort && !timeout && !rerr;
    exp_err = !abort && (timeout || rerr);

    check({tag, ".done"},      32'(done), 32'd1);
    check({tag, ".stable"},    32'(stable_ok), 32'd1);
    check({tag, ".cs_high"},   32'(cs_high), 32'(exp_cs));
    check({tag, ".acks"},      32'(acks), 32'(exp_ack));
    check({tag, ".errs"},      32'(errs), 32'(exp_err));
    check({tag, ".both"},      32'(both), 32'd0);
    check({tag, ".ack_slot"},  32'(end_ack), 32'(exp_ack));
    check({tag, ".err_slot"},  32'(end_err), 32'(exp_err));
    check({tag, ".dat_o"},     bus.wbs_dat_o, exp_dat);
    check({tag, ".sts_tmo"},   32'(sts_tmo), 32'(exp_tmo));
    check({tag, ".last_sid"},  32'(sts_last_sid), 32'(exp_sid));

    if (!keep) begin
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      @(negedge app_clk);
      if (bus.reg_cs !== 1'b1) lo_run++;
      check({tag, ".pulse_end"}, 32'(bus.wbs_ack_o | bus.wbs_err_o), 32'd0);
      drive_junk();
    end
  endtask

  task automatic clear_tmo(input string tag);
    sts_clr = 1'b1;
    @(negedge app_clk);
    sts_clr = 1'b0;
    exp_tmo = 1'b0;
    check(tag, 32'(sts_tmo), 32'd0);
  endtask

  initial begin
    bit   prev_keep;
    bit   keep, abort;
    int   k;
    bit   rose;

    reset_ssn     = 1'b0;
    sts_clr       = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    bus.reg_ack   = 1'b0;
    bus.reg_err   = 1'b0;
    bus.reg_sid   = '0;
    bus.reg_rdata = '0;
    exp_dat = '0; exp_tmo = 1'b0; exp_sid = '0;
    lo_run = 0; last_gap = 0;

    // Reset state.
    repeat (3) @(negedge app_clk);
    check("rst.reg_cs",   32'(bus.reg_cs), 32'd0);
    check("rst.ack",      32'(bus.wbs_ack_o), 32'd0);
    check("rst.err",      32'(bus.wbs_err_o), 32'd0);
    check("rst.dat_o",    bus.wbs_dat_o, 32'h0);
    check("rst.sts_tmo",  32'(sts_tmo), 32'd0);
    check("rst.last_sid", 32'(sts_last_sid), 32'd0);
    reset_ssn = 1'b1;
    @(negedge app_clk);

    // Directed write and read.
    xfer("wr",  11'h040, 1'b1, 32'h0000_00A5, 4'h1, 2, 1'b0, 4'h5, 32'h1234_5678, 0, 0, 0);
    xfer("rd",  11'h084, 1'b0, 32'h0,         4'hF, 2, 1'b0, 4'h9, 32'h0000_0037, 0, 0, 0);

    // Timeout, then clear.
    xfer("tmo", 11'h084, 1'b0, 32'h0,         4'hF, -1, 1'b0, 4'h3, 32'h0, 0, 0, 0);
    check("tmo.dat_const", bus.wbs_dat_o, 32'hDEAD_0084);
    clear_tmo("tmo.clr");

    // Back-to-back writes with stb held.
    xfer("b2b0", 11'h010, 1'b1, 32'hCAFE_0001, 4'h3, 1, 1'b0, 4'h1, 32'h0, 0, 1, 0);
    xfer("b2b1", 11'h014, 1'b1, 32'hCAFE_0002, 4'hC, 3, 1'b0, 4'h2, 32'h0, 0, 0, 0);
    check("b2b.gap", 32'(last_gap), 32'd1);

    // Responder error, then ack on the last counter value.
    xfer("rerr", 11'h020, 1'b0, 32'h0, 4'hF, 3, 1'b1, 4'hA, 32'h0BAD_0BAD, 0, 0, 0);
    xfer("race", 11'h024, 1'b0, 32'h0, 4'hF, TMO_CYC - 1, 1'b0, 4'hB, 32'h5EED_0001, 0, 0, 0);

    // Timeout coinciding with sts_clr keeps the flag set.
    xfer("tmoclr", 11'h3FF, 1'b1, 32'h1, 4'h1, -1, 1'b0, 4'h0, 32'h0, 0, 0, 1);
    clear_tmo("tmoclr.clr");

    // Abort: response suppressed, status still captured.
    xfer("abort", 11'h030, 1'b0, 32'h0, 4'hF, 4, 1'b0, 4'hD, 32'hABCD_EF01, 1, 0, 0);

    // Reset while reg_cs is high.
    bus.reg_ack   = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = 11'h100;
    bus.wbs_we_i  = 1'b0;
    rose = 0;
    for (int c = 0; c < 5 && !rose; c++) begin
      @(negedge app_clk);
      bus.reg_ack = 1'b0;
      if (bus.reg_cs === 1'b1) rose = 1;
    end
    check("mid.cs_rose", 32'(rose), 32'd1);
    @(negedge app_clk);
    reset_ssn     = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    #1;
    check("mid.cs_async", 32'(bus.reg_cs), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge app_clk);
      check("mid.no_resp", 32'(bus.wbs_ack_o | bus.wbs_err_o), 32'd0);
    end
    reset_ssn = 1'b1;
    exp_dat = '0; exp_tmo = 1'b0; exp_sid = '0;
    lo_run = 0;
    @(negedge app_clk);
    check("mid.post_no_resp", 32'(bus.wbs_ack_o | bus.wbs_err_o), 32'd0);
    xfer("post", 11'h104, 1'b0, 32'h0, 4'hF, 1, 1'b0, 4'h7, 32'h0000_0042, 0, 0, 0);

    // Randomized transfers.
    prev_keep = 0;
    for (int i = 0; i < 24; i++) begin
      k     = $urandom_range(1, 6);
      abort = ($urandom_range(0, 7) == 0);
      keep  = !abort && (i != 23) && ($urandom_range(0, 1) == 1);
      xfer($sformatf("rnd%0d", i), 11'($urandom), 1'($urandom_range(0, 1)), $urandom,
           4'($urandom), k, 1'($urandom_range(0, 3) == 0), 4'($urandom), $urandom,
           abort, keep, 0);
      if (prev_keep) check($sformatf("rnd%0d.gap", i), 32'(last_gap), 32'd1);
      prev_keep = keep;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
